// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, encodings and helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic [1:0] STOP_1 = 2'b01;
  localparam logic [1:0] STOP_2 = 2'b10;

  localparam logic [3:0] DATA_SIZE_MIN = 4'd6;
  localparam logic [3:0] DATA_SIZE_MAX = 4'd8;

  // Map any requested payload width onto the supported 6..8 range.
  function automatic logic [3:0] clamp_data_size(input logic [3:0] size);
    if (size > DATA_SIZE_MAX) return DATA_SIZE_MAX;
    if (size < DATA_SIZE_MIN) return DATA_SIZE_MIN;
    return size;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// rtl/uart_tick_gen.sv - divisor counter producing a one-cycle oversample tick
module uart_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] last;

  // A divisor of 0 behaves like 1: tick every cycle.
  assign last   = (divisor_i == '0) ? '0 : divisor_i - 1'b1;
  assign tick_o = !clear_i && (count == last);

  // Count 0..last and wrap; clear holds the phase at zero so a new frame starts aligned.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      count <= '0;
    end else if (count >= last) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversampling UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 rx_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  input  logic [3:0]           data_size_i,
  input  logic                 parity_size_i,
  input  logic                 parity_type_i,
  input  logic [1:0]           stop_size_i,
  input  logic                 fifo_full_i,
  output logic [8:0]           data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2 - 1);

  rx_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_prev, fall;
  logic                   tick, samp, bit_val;
  logic                   start_frame, done, frame_bad;

  logic [TCW-1:0]       tc;
  logic [3:0]           bit_cnt;
  logic [8:0]           data_q;
  logic                 stop_cnt, ferr_q, perr_q;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [3:0]           cfg_size;
  logic                 cfg_par, cfg_odd, cfg_stop2;

  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign fall   = rx_prev && !rx_s;
  assign samp   = tick && (tc == TC_MID);
  assign busy_o = (state_q != IDLE);

  // Bring the asynchronous line into clk_i and keep one extra flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_prev <= rx_s;
    end
  end

  uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_q == IDLE),
    .divisor_i (cfg_div),
    .tick_o    (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote_q;

  // Keep the two tick samples preceding the sample point so the vote resolves on time.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vote_q <= 2'b11;
    end else if (tick) begin
      vote_q <= {vote_q[0], rx_s};
    end
  end

  assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & rx_s) | (vote_q[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // The final stop sample is still on the line when the frame completes, so fold it in here.
  assign frame_bad = ferr_q || !bit_val;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; disabling the receiver aborts any frame silently.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    done        = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (fall) begin state_d = START; start_frame = 1'b1; end
        START:   if (samp) state_d = bit_val ? IDLE : DATA;
        DATA:    if (samp && (bit_cnt == cfg_size - 4'd1)) state_d = cfg_par ? PARITY : STOP;
        PARITY:  if (samp) state_d = STOP;
        STOP:    if (samp && (!cfg_stop2 || stop_cnt)) begin state_d = IDLE; done = 1'b1; end
        default: state_d = IDLE;
      endcase
    end
  end

  // Bit timing, config latch and payload/error capture at each sample point.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tc        <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      stop_cnt  <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      cfg_div   <= DIV_WIDTH'(1);
      cfg_size  <= DATA_SIZE_MAX;
      cfg_par   <= 1'b0;
      cfg_odd   <= 1'b0;
      cfg_stop2 <= 1'b0;
    end else if (start_frame) begin
      tc        <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      stop_cnt  <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      cfg_div   <= divisor_i;
      cfg_size  <= clamp_data_size(data_size_i);
      cfg_par   <= parity_size_i;
      cfg_odd   <= parity_type_i;
      cfg_stop2 <= (stop_size_i == STOP_2);
    end else begin
      // tc runs straight through the start bit, so each later sample lands one bit period on.
      if (tick) tc <= (tc == TC_LAST) ? '0 : tc + 1'b1;
      if (samp) begin
        unique case (state_q)
          DATA: begin
            data_q[bit_cnt] <= bit_val;
            bit_cnt         <= bit_cnt + 4'd1;
          end
          PARITY: perr_q <= ((^data_q) ^ bit_val) != cfg_odd;
          STOP: begin
            if (!bit_val) ferr_q <= 1'b1;
            stop_cnt <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Completion outputs, registered one cycle after the final stop sample.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (!en_i) overrun_o <= 1'b0;
      if (done) begin
        data_o       <= data_q;
        frame_err_o  <= frame_bad;
        parity_err_o <= perr_q;
        if (!frame_bad && !perr_q) begin
          if (fifo_full_i) overrun_o <= 1'b1;
          else             valid_o   <= 1'b1;
        end
      end
    end
  end

endmodule
